// File: rtl/div_ctrl_if.sv
// Handshake and operand bundle between EX and the divider.
// EX drives the request side; the divider returns result, ready and stall.
interface div_ctrl_if #(
   parameter int DW = 32
);
   logic            start_i;
   logic            annul_i;
   logic            signed_div_i;
   logic [DW-1:0]   opdata1_i;
   logic [DW-1:0]   opdata2_i;
   logic [2*DW-1:0] result_o;
   logic            ready_o;
   logic            stall_o;

   modport master (
      output start_i, annul_i, signed_div_i,
      output opdata1_i, opdata2_i,
      input  result_o, ready_o, stall_o
   );

   modport slave (
      input  start_i, annul_i, signed_div_i,
      input  opdata1_i, opdata2_i,
      output result_o, ready_o, stall_o
   );
endinterface

// File: rtl/div_ctrl.sv
// Radix-2 restoring divider for DIV/DIVU.
// Holds {remainder, quotient} until EX drops its request.
module div_ctrl #(
   parameter int DW = 32
) (
   input logic       clk,
   input logic       rst,
   div_ctrl_if.slave bus
);
   localparam int CW = $clog2(DW) + 1;

   typedef enum logic [1:0] {IDLE, BYZERO, ON, END} state_t;

   state_t          state, state_n;
   logic [CW-1:0]   cnt, cnt_n;
   logic [DW-1:0]   dvd, dvd_n;
   logic [DW-1:0]   dsr, dsr_n;
   logic [DW-1:0]   rem, rem_n;
   logic [DW-1:0]   quo, quo_n;
   logic            neg_q, neg_q_n;
   logic            neg_r, neg_r_n;
   logic [2*DW-1:0] result, result_n;
   logic            ready, ready_n;

   logic [DW-1:0]   a_abs, b_abs;
   logic [DW-1:0]   shifted, diff;
   logic            ge;
   logic            go;

   assign go = bus.start_i & ~bus.annul_i;

   assign a_abs = (bus.signed_div_i & bus.opdata1_i[DW-1])
                ? -bus.opdata1_i : bus.opdata1_i;
   assign b_abs = (bus.signed_div_i & bus.opdata2_i[DW-1])
                ? -bus.opdata2_i : bus.opdata2_i;

   // Partial remainder never exceeds the divisor, so DW-bit diff is exact.
   assign shifted = {rem[DW-2:0], dvd[DW-1]};
   assign ge      = {rem, dvd[DW-1]} >= {1'b0, dsr};
   assign diff    = shifted - dsr;

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= '0;
         dvd    <= '0;
         dsr    <= '0;
         rem    <= '0;
         quo    <= '0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         result <= '0;
         ready  <= 1'b0;
      end else begin
         state  <= state_n;
         cnt    <= cnt_n;
         dvd    <= dvd_n;
         dsr    <= dsr_n;
         rem    <= rem_n;
         quo    <= quo_n;
         neg_q  <= neg_q_n;
         neg_r  <= neg_r_n;
         result <= result_n;
         ready  <= ready_n;
      end
   end

   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      dvd_n    = dvd;
      dsr_n    = dsr;
      rem_n    = rem;
      quo_n    = quo;
      neg_q_n  = neg_q;
      neg_r_n  = neg_r;
      result_n = result;
      ready_n  = ready;
      unique case (state)
         IDLE: begin
            if (go && bus.opdata2_i == '0) begin
               state_n = BYZERO;
               cnt_n   = '0;
            end else if (go) begin
               state_n = ON;
               cnt_n   = '0;
               dvd_n   = a_abs;
               dsr_n   = b_abs;
               rem_n   = '0;
               quo_n   = '0;
               neg_q_n = bus.signed_div_i
                       & (bus.opdata1_i[DW-1] ^ bus.opdata2_i[DW-1]);
               neg_r_n = bus.signed_div_i & bus.opdata1_i[DW-1];
            end
         end
         BYZERO: begin
            // One settle cycle gives zero-divide a two-edge latency.
            if (cnt == '0) begin
               cnt_n = CW'(1);
            end else begin
               state_n  = END;
               result_n = '0;
               ready_n  = 1'b1;
            end
         end
         ON: begin
            if (bus.annul_i) begin
               state_n = IDLE;
            end else if (cnt != CW'(DW)) begin
               rem_n = ge ? diff : shifted;
               quo_n = {quo[DW-2:0], ge};
               dvd_n = {dvd[DW-2:0], 1'b0};
               cnt_n = cnt + CW'(1);
            end else begin
               state_n  = END;
               ready_n  = 1'b1;
               result_n = {neg_r ? -rem : rem,
                           neg_q ? -quo : quo};
            end
         end
         END: begin
            if (bus.annul_i || !bus.start_i) begin
               state_n  = IDLE;
               ready_n  = 1'b0;
               result_n = '0;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   assign bus.result_o = result;
   assign bus.ready_o  = ready;
   assign bus.stall_o  = go & (state != END);
endmodule
